// File: rtl/flag_branch_unit.sv
// flag_branch_unit: NZCV flag register plus EX-stage branch resolution.
// Resolves B, CBZ and B.cond branches, pulses taken, and holds flush for
// FLUSH_CYCLES cycles (legal 1..7) after every taken branch.
// Optional macro FLAG_BRANCH_FWD_EN: a B.cond issued together with a
// flag-setting instruction evaluates on alu_nzcv directly instead of
// stalling one cycle in WAIT_FLAG.
module flag_branch_unit #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       set_flags,
    input  logic [3:0] alu_nzcv,
    input  logic       br_valid,
    input  logic [1:0] br_type,
    input  logic [3:0] br_cond,
    input  logic       cbz_zero,
    output logic       br_accept,
    output logic       taken,
    output logic       stall,
    output logic       flush,
    output logic [3:0] flags
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_FLAG = 2'd1;
    localparam logic [1:0] ST_FLUSH     = 2'd2;

    localparam logic [1:0] BR_B    = 2'b00;
    localparam logic [1:0] BR_CBZ  = 2'b01;
    localparam logic [1:0] BR_COND = 2'b10;

    // The counter runs FLUSH_CYCLES-1 .. 0, one flush cycle per value.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] flags_q, flags_d;
    logic       accept_c, taken_c, stall_c, flush_c;

    // ARM condition check: cond[3:1] picks the base test, cond[0] inverts it,
    // except 0xF which stays "always" like 0xE.
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, base;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond[3:1])
            3'b000:  base = z;
            3'b001:  base = c;
            3'b010:  base = n;
            3'b011:  base = v;
            3'b100:  base = c & ~z;
            3'b101:  base = (n == v);
            3'b110:  base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return (cond[0] && cond != 4'hF) ? ~base : base;
    endfunction

    // Next-state, flush counter, flag register and handshake outputs.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        flags_d  = set_flags ? alu_nzcv : flags_q;
        accept_c = 1'b0;
        taken_c  = 1'b0;
        stall_c  = 1'b0;
        flush_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (br_valid) begin
                    case (br_type)
                        BR_B: begin
                            accept_c = 1'b1;
                            taken_c  = 1'b1;
                        end
                        BR_CBZ: begin
                            accept_c = 1'b1;
                            taken_c  = cbz_zero;
                        end
                        BR_COND: begin
`ifdef FLAG_BRANCH_FWD_EN
                            // Forward this cycle's ALU flags instead of waiting for the register.
                            accept_c = 1'b1;
                            taken_c  = cond_holds(br_cond, set_flags ? alu_nzcv : flags_q);
`else
                            if (set_flags) begin
                                // Flags not yet visible: freeze the pipe one cycle.
                                stall_c = 1'b1;
                                state_d = ST_WAIT_FLAG;
                            end else begin
                                accept_c = 1'b1;
                                taken_c  = cond_holds(br_cond, flags_q);
                            end
`endif
                        end
                        default: accept_c = 1'b1;  // reserved type: retire as not taken
                    endcase
                end
            end
            ST_WAIT_FLAG: begin
                // Branch inputs are held stable; flags register now holds the new value.
                accept_c = 1'b1;
                taken_c  = cond_holds(br_cond, flags_q);
            end
            ST_FLUSH: begin
                flush_c = 1'b1;
                if (cnt_q == 3'd0) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 3'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (taken_c) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_LOAD;
        end else if (accept_c) begin
            state_d = ST_IDLE;
        end
    end

    // State, counter and architectural flags with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            flags_q <= 4'b0000;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
        end
    end

    // Outputs are gated by reset_n so nothing rises while reset is held.
    assign br_accept = accept_c & reset_n;
    assign taken     = taken_c  & reset_n;
    assign stall     = stall_c  & reset_n;
    assign flush     = flush_c  & reset_n;
    assign flags     = flags_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed self-checking bench for flag_branch_unit (FLUSH_CYCLES = 2, 1, 7).
module tb_flag_branch_unit;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       set_flags = 1'b0;
    logic [3:0] alu_nzcv = 4'h0;
    logic       br_valid = 1'b0;
    logic [1:0] br_type = 2'b00;
    logic [3:0] br_cond = 4'h0;
    logic       cbz_zero = 1'b0;

    logic       br_accept, taken, stall, flush;
    logic [3:0] flags;
    logic       acc1, tkn1, stl1, fls1, acc7, tkn7, stl7, fls7;
    logic [3:0] flg1, flg7;

    typedef struct {
        logic  acc, tkn, stl, fls;
        logic [3:0] flg;
        string tag;
    } exp_t;

    exp_t       sb_q[$];
    int         tests = 0;
    int         failed = 0;
    logic [3:0] model_flags = 4'h0;

    flag_branch_unit dut (
        .clk(clk), .reset_n(reset_n), .set_flags(set_flags), .alu_nzcv(alu_nzcv),
        .br_valid(br_valid), .br_type(br_type), .br_cond(br_cond), .cbz_zero(cbz_zero),
        .br_accept(br_accept), .taken(taken), .stall(stall), .flush(flush), .flags(flags)
    );

    flag_branch_unit #(.FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .set_flags(set_flags), .alu_nzcv(alu_nzcv),
        .br_valid(br_valid), .br_type(br_type), .br_cond(br_cond), .cbz_zero(cbz_zero),
        .br_accept(acc1), .taken(tkn1), .stall(stl1), .flush(fls1), .flags(flg1)
    );

    flag_branch_unit #(.FLUSH_CYCLES(7)) dut7 (
        .clk(clk), .reset_n(reset_n), .set_flags(set_flags), .alu_nzcv(alu_nzcv),
        .br_valid(br_valid), .br_type(br_type), .br_cond(br_cond), .cbz_zero(cbz_zero),
        .br_accept(acc7), .taken(tkn7), .stall(stl7), .flush(fls7), .flags(flg7)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference condition table, written out case by case.
    function automatic logic cond_model(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, queue expected outputs, compare at negedge.
    task automatic cyc(input logic sf, input logic [3:0] nz, input logic bv, input logic [1:0] bt,
                       input logic [3:0] bc, input logic cz,
                       input logic e_acc, input logic e_tkn, input logic e_stl, input logic e_fls,
                       input string tag);
        exp_t e;
        set_flags = sf; alu_nzcv = nz; br_valid = bv; br_type = bt; br_cond = bc; cbz_zero = cz;
        e.acc = e_acc; e.tkn = e_tkn; e.stl = e_stl; e.fls = e_fls;
        e.flg = reset_n ? model_flags : 4'h0;
        e.tag = tag;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        chk({e.tag, ".accept"}, {3'b000, br_accept}, {3'b000, e.acc});
        chk({e.tag, ".taken"},  {3'b000, taken},     {3'b000, e.tkn});
        chk({e.tag, ".stall"},  {3'b000, stall},     {3'b000, e.stl});
        chk({e.tag, ".flush"},  {3'b000, flush},     {3'b000, e.fls});
        chk({e.tag, ".flags"},  flags,               e.flg);
        @(posedge clk);
        if (!reset_n)  model_flags = 4'h0;
        else if (sf)   model_flags = nz;
        #1;
    endtask

    task automatic idle(input string tag);
        cyc(0, 4'h0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic flush_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(0, 4'h0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 1, tag);
    endtask

    task automatic load_flags(input logic [3:0] nz, input string tag);
        cyc(1, nz, 0, 2'b00, 4'h0, 0, 0, 0, 0, 0, tag);
    endtask

    // One-cycle branch resolution followed by its two flush cycles when taken.
    task automatic branch(input logic [1:0] bt, input logic [3:0] bc, input logic cz,
                          input logic e_tkn, input string tag);
        cyc(0, 4'h0, 1, bt, bc, cz, 1, e_tkn, 0, 0, tag);
        if (e_tkn) flush_cycles(2, {tag, ".fl"});
    endtask

    initial begin
        int fw[3], tk[3], ac[3], st[3];

        // Reset held with a branch and flag write present: nothing may rise.
        reset_n = 1'b0;
        cyc(1, 4'hF, 1, 2'b00, 4'h0, 0, 0, 0, 0, 0, "rst_glitch");
        reset_n = 1'b1;
        idle("idle0");

        // Flags then B.cond EQ next cycle.
        load_flags(4'b0100, "ld_z");
        cyc(0, 4'h0, 1, 2'b10, 4'h0, 0, 1, 1, 0, 0, "beq");
        flush_cycles(2, "beq.fl");
        idle("beq.after");

        // CBZ not taken, CBZ taken, then held br_valid across the flush.
        cyc(0, 4'h0, 1, 2'b01, 4'h0, 0, 1, 0, 0, 0, "cbz_nt");
        idle("cbz_nt.after");
        cyc(0, 4'h0, 1, 2'b01, 4'h0, 1, 1, 1, 0, 0, "cbz_t");
        cyc(0, 4'h0, 1, 2'b01, 4'h0, 1, 0, 0, 0, 1, "cbz_hold1");
        cyc(0, 4'h0, 1, 2'b01, 4'h0, 1, 0, 0, 0, 1, "cbz_hold2");
        cyc(0, 4'h0, 1, 2'b01, 4'h0, 1, 1, 1, 0, 0, "cbz_again");
        flush_cycles(2, "cbz_again.fl");
        idle("cbz.after");

        // Reserved type retires not taken.
        cyc(0, 4'h0, 1, 2'b11, 4'hE, 1, 1, 0, 0, 0, "rsvd");
        idle("rsvd.after");

        // Flag write alongside B / CBZ must not delay them.
        cyc(1, 4'b1001, 1, 2'b00, 4'h0, 0, 1, 1, 0, 0, "b_sf");
        flush_cycles(2, "b_sf.fl");
        cyc(1, 4'b0011, 1, 2'b01, 4'h0, 0, 1, 0, 0, 0, "cbz_sf");
        idle("cbz_sf.after");

        // Same-cycle hazard: flag write together with B.cond EQ.
        load_flags(4'b0000, "hz_clr");
`ifdef FLAG_BRANCH_FWD_EN
        cyc(1, 4'b0100, 1, 2'b10, 4'h0, 0, 1, 1, 0, 0, "hz_t");
        flush_cycles(2, "hz_t.fl");
        cyc(1, 4'b0000, 1, 2'b10, 4'h0, 0, 1, 0, 0, 0, "hz_nt");
`else
        cyc(1, 4'b0100, 1, 2'b10, 4'h0, 0, 0, 0, 1, 0, "hz_t.stall");
        cyc(0, 4'h0,    1, 2'b10, 4'h0, 0, 1, 1, 0, 0, "hz_t.res");
        flush_cycles(2, "hz_t.fl");
        cyc(1, 4'b0000, 1, 2'b10, 4'h0, 0, 0, 0, 1, 0, "hz_nt.stall");
        cyc(0, 4'h0,    1, 2'b10, 4'h0, 0, 1, 0, 0, 0, "hz_nt.res");
`endif
        idle("hz.after");

        // Every NZCV value against every condition code from the flags register.
        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f), $sformatf("sw_ld%0h", f));
            for (int c = 0; c < 16; c++)
                branch(2'b10, 4'(c), 0, cond_model(4'(c), 4'(f)), $sformatf("sw_f%0h_c%0h", f, c));
        end

        // Reset in the 2nd flush cycle aborts the flush and clears flags.
        cyc(0, 4'h0, 1, 2'b00, 4'h0, 0, 1, 1, 0, 0, "rf_b");
        flush_cycles(1, "rf_fl1");
        reset_n = 1'b0;
        idle("rf_rst");
        reset_n = 1'b1;
        branch(2'b00, 4'h0, 0, 1, "rf_b2");
        idle("rf.after");

        // Flush width for FLUSH_CYCLES = 2, 1, 7 from a common reset.
        reset_n = 1'b0;
        idle("w_rst");
        reset_n = 1'b1;
        fw = '{0, 0, 0}; tk = '{0, 0, 0}; ac = '{0, 0, 0}; st = '{0, 0, 0};
        set_flags = 0; br_valid = 1; br_type = 2'b00;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            fw[0] += int'(flush); fw[1] += int'(fls1); fw[2] += int'(fls7);
            tk[0] += int'(taken); tk[1] += int'(tkn1); tk[2] += int'(tkn7);
            ac[0] += int'(br_accept); ac[1] += int'(acc1); ac[2] += int'(acc7);
            st[0] += int'(stall); st[1] += int'(stl1); st[2] += int'(stl7);
            @(posedge clk); #1;
            br_valid = 0;
        end
        chk("w2.flush_width", 4'(fw[0]), 4'd2);
        chk("w1.flush_width", 4'(fw[1]), 4'd1);
        chk("w7.flush_width", 4'(fw[2]), 4'd7);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("w%0d.taken_count", k),  4'(tk[k]), 4'd1);
            chk($sformatf("w%0d.accept_count", k), 4'(ac[k]), 4'd1);
            chk($sformatf("w%0d.stall_count", k),  4'(st[k]), 4'd0);
        end
        chk("w1.flags", flg1, 4'h0);
        chk("w7.flags", flg7, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/flag_branch_unit.md
FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 Parameter: FLUSH_CYCLES, default 2, number of cycles flush is held after a taken branch (legal 1..7).
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: set_flags  input  1  EX-stage flag-setting instruction this cycle.
REQ-005 Port: alu_nzcv  input  4  {N,Z,C,V} from ALU; Z comes from the zero-detect reduction tree.
REQ-006 Port: br_valid  input  1  branch present in EX; held stable until accepted.
REQ-007 Port: br_type  input  2  00 B, 01 CBZ, 10 B.cond, 11 reserved.
REQ-008 Port: br_cond  input  4  condition code, ARM encoding 0x0 EQ .. 0xD LE, 0xE/0xF always.
REQ-009 Port: cbz_zero  input  1  zero-detect of the CBZ operand register.
REQ-010 Port: br_accept  output  1  branch resolved this cycle (handshake completion).
REQ-011 Port: taken  output  1  one-cycle pulse, coincident with br_accept, branch taken.
REQ-012 Port: stall  output  1  freeze IF/ID/EX this cycle.
REQ-013 Port: flush  output  1  squash IF/ID contents.
REQ-014 Port: flags  output  4  architectural NZCV register.

Function
REQ-015 flags SHALL load alu_nzcv on a clock edge where set_flags=1; otherwise hold.
REQ-016 FSM states SHALL be IDLE, WAIT_FLAG, FLUSH.
REQ-017 IDLE, br_valid=0: br_accept=0, taken=0, stall=0, flush=0.
REQ-018 IDLE, br_valid=1, br_type=00: br_accept=1, taken=1 same cycle; next state FLUSH.
REQ-019 IDLE, br_valid=1, br_type=01: br_accept=1, taken=cbz_zero same cycle; taken -> FLUSH, else stay IDLE.
REQ-020 IDLE, br_valid=1, br_type=10, set_flags=0: evaluate br_cond on flags register, br_accept=1 same cycle; taken -> FLUSH, else IDLE.
REQ-021 br_type=11 SHALL be accepted as not taken in one cycle.
REQ-022 Condition evaluation SHALL follow ARM semantics: EQ Z, NE !Z, HS C, LO !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), 0xE/0xF always.
REQ-023 FLUSH: flush=1, stall=0, br_accept=0 for exactly FLUSH_CYCLES cycles via down-counter, then IDLE; br_valid ignored while in FLUSH.
REQ-024 taken SHALL never assert for two consecutive cycles.
REQ-025 set_flags together with a branch whose type is not 10 SHALL not delay that branch.

Reset
REQ-026 reset_n=0 SHALL asynchronously force state IDLE, flags=4'b0000, flush counter 0, and br_accept, taken, stall, flush all 0.
REQ-027 Reset asserted in WAIT_FLAG or FLUSH SHALL abort the operation; first cycle after release behaves as IDLE with no pending branch.
REQ-028 Deassertion is synchronised externally; no output SHALL glitch high while reset_n=0.

Configuration
REQ-029 Macro FLAG_BRANCH_FWD_EN compiled in: B.cond with set_flags=1 in the same cycle evaluates on alu_nzcv combinationally and resolves in that cycle as REQ-020; WAIT_FLAG is unreachable.
REQ-030 FLAG_BRANCH_FWD_EN absent: B.cond with set_flags=1 asserts stall=1, br_accept=0, enters WAIT_FLAG; next cycle resolves on the updated flags register with stall=0, then FLUSH or IDLE.

Verification
REQ-031 Reset mid-FLUSH: B taken, reset_n=0 in 2nd flush cycle -> flush=0 immediately, flags=0000, next br_valid B resolves normally.
REQ-032 Flags then B.cond: set_flags=1 alu_nzcv=0100, next cycle B.cond EQ -> br_accept=1, taken=1, flush high exactly 2 cycles.
REQ-033 GE/LT sweep: all 16 NZCV values x cond 0xA,0xB,0xC,0xD from flags register -> taken matches REQ-022 table every case.
REQ-034 Same-cycle hazard: flags=0000, set_flags=1 alu_nzcv=0100 with B.cond EQ -> with macro taken=1 that cycle; without macro stall=1 one cycle then taken=1.
REQ-035 CBZ: cbz_zero=0 -> br_accept=1, taken=0, no flush; cbz_zero=1 -> taken=1, flush 2 cycles; back-to-back br_valid during FLUSH -> not accepted until IDLE.
REQ-036 FLUSH_CYCLES=1 and 7: B taken -> flush width exactly 1 and 7 cycles respectively.
